// File: rtl/alu_mc_sequencer_if.sv
// Control bundle between decode/EX control and the multi-cycle ALU sequencer.
// dbg_state/dbg_cnt expose the sequencer FSM for external checkers.
interface alu_mc_sequencer_if #(
   parameter int CNT_W = 3
);
   // Handshake: issue_valid presents an op in EX; n_stall=1 means the EX
   // instruction is accepted downstream this cycle; alu_nstall=0 is the
   // sequencer's back-pressure holding the pipeline while an op is in flight.
   logic             n_stall;
   logic             issue_valid;
   logic [6:0]       aluctl;
   logic             flush;
   logic             alu_nstall;
   logic             unit_start;
   logic             res_valid;
   logic             busy;
   logic [1:0]       op_lat;
   logic [31:0]      perf_stall;
   logic [31:0]      perf_mcops;
   logic [1:0]       dbg_state;
   logic [CNT_W-1:0] dbg_cnt;

   modport master (
      output n_stall, issue_valid, aluctl, flush,
      input  alu_nstall, unit_start, res_valid, busy, op_lat,
      input  perf_stall, perf_mcops, dbg_state, dbg_cnt
   );

   modport slave (
      input  n_stall, issue_valid, aluctl, flush,
      output alu_nstall, unit_start, res_valid, busy, op_lat,
      output perf_stall, perf_mcops, dbg_state, dbg_cnt
   );
endinterface

// File: rtl/alu_mc_sequencer.sv
// Multi-cycle FP op sequencer: start pulse, latency stall, result-valid flag.
// Optional performance counters enabled by defining ALU_MC_PERF_EN.
module alu_mc_sequencer #(
   parameter int LAT_L1 = 1,
   parameter int LAT_L2 = 2,
   parameter int LAT_L3 = 3,
   parameter int CNT_W  = 3
) (
   input logic               clk,
   input logic               rst,
   alu_mc_sequencer_if.slave sq
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic [CNT_W-1:0] w_lat;
   logic [1:0]       w_class;
   logic             w_fire;
   logic             w_stall;
   logic             w_unused_ctl;

   assign w_unused_ctl = sq.aluctl[6];

   always_comb begin
      w_class = 2'd0;
      case (sq.aluctl[5:0])
         6'b010110, 6'b010111, 6'b011001, 6'b011010: w_class = 2'd1;
         6'b010000, 6'b010001, 6'b010010, 6'b010100: w_class = 2'd2;
         6'b010011:                                  w_class = 2'd3;
         default:                                    w_class = 2'd0;
      endcase
   end

   always_comb begin
      w_lat = '0;
      case (w_class)
         2'd1:    w_lat = CNT_W'(LAT_L1);
         2'd2:    w_lat = CNT_W'(LAT_L2);
         2'd3:    w_lat = CNT_W'(LAT_L3);
         default: w_lat = '0;
      endcase
   end

   // Launch only from IDLE, so an op held in DONE by a stall never re-fires.
   assign w_fire = (r_state == S_IDLE) && sq.issue_valid && (w_class != 2'd0) && !sq.flush;

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      if (sq.flush) begin
         w_next     = S_IDLE;
         w_cnt_next = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_fire) begin
                  w_cnt_next = w_lat - CNT_W'(1);
                  w_next     = (w_lat > CNT_W'(1)) ? S_RUN : S_DONE;
               end
            end
            S_RUN: begin
               w_cnt_next = r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) w_next = S_DONE;
            end
            S_DONE: begin
               if (sq.n_stall) w_next = S_IDLE;
            end
            default: begin
               w_next     = S_IDLE;
               w_cnt_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Outputs are forced to their quiet values while rst is high.
   assign w_stall       = !rst && !sq.flush && (w_fire || (r_state == S_RUN));
   assign sq.alu_nstall = !w_stall;
   assign sq.unit_start = !rst && w_fire;
   assign sq.res_valid  = !rst && (r_state == S_DONE);
   assign sq.busy       = !rst && (r_state != S_IDLE);
   assign sq.op_lat     = w_class;
   assign sq.dbg_state  = r_state;
   assign sq.dbg_cnt    = r_cnt;

`ifdef ALU_MC_PERF_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_mcops;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_stall <= '0;
         r_perf_mcops <= '0;
      end else begin
         if (w_stall) r_perf_stall <= r_perf_stall + 32'd1;
         if (!sq.flush && (r_state == S_DONE) && sq.n_stall) r_perf_mcops <= r_perf_mcops + 32'd1;
      end
   end

   assign sq.perf_stall = r_perf_stall;
   assign sq.perf_mcops = r_perf_mcops;
`else
   assign sq.perf_stall = 32'd0;
   assign sq.perf_mcops = 32'd0;
`endif
endmodule

// File: tb/tb_alu_mc_sequencer.sv
// Directed bench for alu_mc_sequencer: per-cycle vector table plus hand-written
// sequences for stall-hold, flush and reset corner cases.
module tb_alu_mc_sequencer;
   localparam logic [6:0] OP_ADD   = 7'b0000000;
   localparam logic [6:0] OP_FADD  = 7'b0010000;
   localparam logic [6:0] OP_FMUL  = 7'b0010010;
   localparam logic [6:0] OP_FDIV  = 7'b0010011;
   localparam logic [6:0] OP_FSQRT = 7'b0010100;
   localparam logic [6:0] OP_FNEG  = 7'b0010101;
   localparam logic [6:0] OP_FEQ   = 7'b0011000;
   localparam logic [6:0] OP_FLT6  = 7'b1011001;
   localparam int         NVEC     = 19;

   typedef struct {
      logic       rst;
      logic       iv;
      logic [6:0] ctl;
      logic       fl;
      logic       ns;
      logic [5:0] e_out;
      int         e_ps;
      int         e_mc;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   vec_t tbl[NVEC];
   logic [5:0] exp_q[$];
   int   n_start;
   int   n_valid;

   alu_mc_sequencer_if #(.CNT_W(3)) sq ();

   alu_mc_sequencer #(.LAT_L1(1), .LAT_L2(2), .LAT_L3(3), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .sq  (sq)
   );

   // clock / reset
   always #5 clk = ~clk;

   // driver tasks
   task automatic drive(input logic r, input logic iv, input logic [6:0] ctl,
                        input logic fl, input logic ns);
      @(posedge clk);
      #1;
      rst            = r;
      sq.issue_valid = iv;
      sq.aluctl      = ctl;
      sq.flush       = fl;
      sq.n_stall     = ns;
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic int expp(input int v);
`ifdef ALU_MC_PERF_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   // {alu_nstall, unit_start, res_valid, busy, op_lat}
   function automatic vec_t mk(input logic r, input logic iv, input logic [6:0] ctl,
                               input logic fl, input logic ns, input logic e_nst,
                               input logic e_st, input logic e_rv, input logic e_bsy,
                               input logic [1:0] e_lat, input int e_ps, input int e_mc);
      vec_t v;
      v.rst   = r;
      v.iv    = iv;
      v.ctl   = ctl;
      v.fl    = fl;
      v.ns    = ns;
      v.e_out = {e_nst, e_st, e_rv, e_bsy, e_lat};
      v.e_ps  = e_ps;
      v.e_mc  = e_mc;
      return v;
   endfunction

   function automatic logic [5:0] outs();
      return {sq.alu_nstall, sq.unit_start, sq.res_valid, sq.busy, sq.op_lat};
   endfunction

   initial begin
      sq.issue_valid = 1'b0;
      sq.aluctl      = OP_ADD;
      sq.flush       = 1'b0;
      sq.n_stall     = 1'b1;

      //             rst iv ctl       fl ns  nst st rv bsy lat  ps mc
      tbl[0]  = mk(1, 0, OP_ADD,   0, 1,  1, 0, 0, 0, 2'd0, 0, 0);
      tbl[1]  = mk(1, 1, OP_FDIV,  0, 1,  1, 0, 0, 0, 2'd3, 0, 0);
      tbl[2]  = mk(0, 0, OP_FDIV,  0, 1,  1, 0, 0, 0, 2'd3, 0, 0);
      tbl[3]  = mk(0, 0, OP_ADD,   0, 1,  1, 0, 0, 0, 2'd0, 0, 0);
      tbl[4]  = mk(0, 1, OP_FDIV,  0, 1,  0, 1, 0, 0, 2'd3, 0, 0);
      tbl[5]  = mk(0, 1, OP_FDIV,  0, 1,  0, 0, 0, 1, 2'd3, 1, 0);
      tbl[6]  = mk(0, 1, OP_FDIV,  0, 1,  0, 0, 0, 1, 2'd3, 2, 0);
      tbl[7]  = mk(0, 1, OP_FDIV,  0, 1,  1, 0, 1, 1, 2'd3, 3, 0);
      tbl[8]  = mk(0, 0, OP_ADD,   0, 1,  1, 0, 0, 0, 2'd0, 3, 1);
      tbl[9]  = mk(0, 1, OP_ADD,   0, 1,  1, 0, 0, 0, 2'd0, 3, 1);
      tbl[10] = mk(0, 1, OP_FNEG,  0, 1,  1, 0, 0, 0, 2'd0, 3, 1);
      tbl[11] = mk(0, 1, OP_FEQ,   0, 1,  1, 0, 0, 0, 2'd0, 3, 1);
      tbl[12] = mk(0, 1, OP_FLT6,  0, 1,  0, 1, 0, 0, 2'd1, 3, 1);
      tbl[13] = mk(0, 1, OP_FLT6,  0, 1,  1, 0, 1, 1, 2'd1, 4, 1);
      tbl[14] = mk(0, 0, OP_ADD,   0, 1,  1, 0, 0, 0, 2'd0, 4, 2);
      tbl[15] = mk(0, 1, OP_FMUL,  0, 1,  0, 1, 0, 0, 2'd2, 4, 2);
      tbl[16] = mk(0, 1, OP_FMUL,  0, 1,  0, 0, 0, 1, 2'd2, 5, 2);
      tbl[17] = mk(0, 1, OP_FMUL,  0, 1,  1, 0, 1, 1, 2'd2, 6, 2);
      tbl[18] = mk(0, 0, OP_ADD,   0, 1,  1, 0, 0, 0, 2'd0, 6, 3);

      // table-driven: reset, idle, fdiv, class-0 ops, flt -> bubble -> fmul
      for (int i = 0; i < NVEC; i++) begin
         exp_q.push_back(tbl[i].e_out);
         drive(tbl[i].rst, tbl[i].iv, tbl[i].ctl, tbl[i].fl, tbl[i].ns);
         chk($sformatf("row%0d outs", i), 32'(outs()), 32'(exp_q.pop_front()));
         chk($sformatf("row%0d perf_stall", i), sq.perf_stall, expp(tbl[i].e_ps));
         chk($sformatf("row%0d perf_mcops", i), sq.perf_mcops, expp(tbl[i].e_mc));
      end

      // fadd held in DONE by four stalled cycles
      n_start = 0;
      n_valid = 0;
      for (int c = 0; c < 8; c++) begin
         drive(1'b0, c < 7, OP_FADD, 1'b0, c >= 6);
         n_start += int'(sq.unit_start);
         n_valid += int'(sq.res_valid);
         if (c == 0) chk("fadd start_c0", 32'(sq.unit_start), 32'd1);
         if (c == 6) chk("fadd state_c6", 32'(sq.dbg_state), 32'd2);
         if (c == 7) chk("fadd busy_c7", 32'(sq.busy), 32'd0);
      end
      chk("fadd start_count", n_start, 32'd1);
      chk("fadd valid_count", n_valid, 32'd5);
      chk("fadd perf_stall", sq.perf_stall, expp(8));
      chk("fadd perf_mcops", sq.perf_mcops, expp(4));

      // fsqrt flushed in its first RUN cycle
      n_valid = 0;
      drive(1'b0, 1'b1, OP_FSQRT, 1'b0, 1'b1);
      chk("flush start_c0", 32'(sq.unit_start), 32'd1);
      drive(1'b0, 1'b1, OP_FSQRT, 1'b1, 1'b1);
      n_valid += int'(sq.res_valid);
      chk("flush nstall_c1", 32'(sq.alu_nstall), 32'd1);
      chk("flush busy_c1", 32'(sq.busy), 32'd1);
      drive(1'b0, 1'b0, OP_ADD, 1'b0, 1'b1);
      n_valid += int'(sq.res_valid);
      chk("flush state_c2", 32'(sq.dbg_state), 32'd0);
      chk("flush valid_none", n_valid, 32'd0);
      chk("flush perf_stall", sq.perf_stall, expp(9));
      chk("flush perf_mcops", sq.perf_mcops, expp(4));

      // flush on the issue cycle suppresses the launch
      drive(1'b0, 1'b1, OP_FDIV, 1'b1, 1'b1);
      chk("flush_issue start", 32'(sq.unit_start), 32'd0);
      chk("flush_issue nstall", 32'(sq.alu_nstall), 32'd1);
      drive(1'b0, 1'b0, OP_ADD, 1'b0, 1'b1);
      chk("flush_issue busy", 32'(sq.busy), 32'd0);

      // reset while fdiv is in RUN
      drive(1'b0, 1'b1, OP_FDIV, 1'b0, 1'b1);
      drive(1'b0, 1'b1, OP_FDIV, 1'b0, 1'b1);
      chk("rst_run cnt_c1", 32'(sq.dbg_cnt), 32'd2);
      drive(1'b1, 1'b1, OP_FDIV, 1'b0, 1'b1);
      chk("rst_run outs_c2", 32'(outs()), 32'({1'b1, 1'b0, 1'b0, 1'b0, 2'd3}));
      drive(1'b0, 1'b0, OP_ADD, 1'b0, 1'b1);
      chk("rst_run state", 32'(sq.dbg_state), 32'd0);
      chk("rst_run cnt", 32'(sq.dbg_cnt), 32'd0);
      chk("rst_run valid", 32'(sq.res_valid), 32'd0);
      chk("rst_run perf_stall", sq.perf_stall, 32'd0);
      chk("rst_run perf_mcops", sq.perf_mcops, 32'd0);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_mc_sequencer.md
Name: alu_mc_sequencer

Overview:
- Controls multi-cycle ALU ops (FP add/sub/mul/div/sqrt/min/max/compare) for the execute stage.
- Decodes the op's latency from aluctl and fires a one-cycle start pulse to the FP units.
- Stalls the pipeline for exactly the op's latency, then flags the cycle the result is valid.
- Never re-triggers an op that is still held in EX by a downstream stall; sits between decode/EX control and the ALU, replacing ad-hoc latency counting.

Parameters:
- LAT_L1, 1, latency in stall cycles for fmin/fmax/flt/fle.
- LAT_L2, 2, latency for fadd/fsub/fmul/fsqrt.
- LAT_L3, 3, latency for fdiv.
- CNT_W, 3, latency counter width; must hold max(LAT_*).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- n_stall  in  1  downstream pipeline advancing this cycle (1 = EX instruction leaves).
- issue_valid  in  1  valid instruction present in EX.
- aluctl  in  7  ALU control; bits [5:0] select the op.
- flush  in  1  branch/jump flush; kills the EX instruction.
- alu_nstall  out  1  0 = hold the pipeline (multi-cycle op in flight).
- unit_start  out  1  one-cycle pulse launching the FP unit.
- res_valid  out  1  ALU result valid this cycle (capture enable for wb_res).
- busy  out  1  state != IDLE.
- op_lat  out  2  decoded latency class of the current aluctl (0..3).
- perf_stall  out  32  stall-cycle count (optional feature).
- perf_mcops  out  32  completed multi-cycle op count (optional feature).

Behaviour:
- Latency decode is combinational on aluctl[5:0]:
  - 010110, 010111, 011001, 011010 -> class 1 (LAT_L1).
  - 010000, 010001, 010010, 010100 -> class 2 (LAT_L2).
  - 010011 -> class 3 (LAT_L3).
  - All other codes -> class 0, including fneg 010101 and feq 011000.
- L denotes the parameter value for the decoded class.
- States are IDLE, RUN and DONE. Register cnt is CNT_W wide.
- IDLE:
  - If issue_valid && class!=0 && !flush: unit_start=1, alu_nstall=0, cnt<=L-1, next state RUN if L>1, else DONE.
  - Otherwise alu_nstall=1 and unit_start=0; class-0 ops pass through with no stall.
- RUN: alu_nstall=0, cnt<=cnt-1; when cnt==1, next state DONE.
- DONE:
  - alu_nstall=1, res_valid=1.
  - If n_stall=1, next state IDLE.
  - If n_stall=0, stay in DONE holding res_valid=1; no new unit_start and no recount (the same aluctl is still present).
- Net effect: an op of latency L stalls exactly L cycles after the issue cycle. The result is valid on cycle L counted from the issue cycle (cycle 0).
- res_valid is 1 only in DONE. For class-0 ops the ALU result is combinational and res_valid stays 0; EX captures on n_stall as usual.
- Back-to-back ops:
  - The next multi-cycle op is issued in the IDLE cycle following DONE && n_stall.
  - There is no issue from DONE.
- Flush has priority over everything except rst:
  - In any state, flush=1 -> next state IDLE, cnt<=0, unit_start=0 in that cycle, alu_nstall=1 in that cycle.
  - Results of an in-flight unit are ignored.
- rst (synchronous):
  - state=IDLE, cnt=0, perf counters=0.
  - During rst: alu_nstall=1, unit_start=0, res_valid=0, busy=0.
  - A reset mid-RUN aborts without completion.
- issue_valid=0 in IDLE: no action regardless of aluctl.
- aluctl[6] is ignored for latency decode.

Optional Feature:
- Macro: ALU_MC_PERF_EN.
- Defined:
  - perf_stall increments on every cycle with alu_nstall=0.
  - perf_mcops increments on each DONE->IDLE transition taken via n_stall; a flush does not count.
  - Both counters wrap modulo 2^32 and are cleared by rst.
- Undefined: both outputs are tied to 0 and no counter flops are synthesized.

Test Plan:
- Reset, then idle with issue_valid=0 -> alu_nstall=1, busy=0, unit_start=0, res_valid=0 every cycle.
- fdiv (aluctl=0010011), n_stall=1 -> unit_start at cycle 0; alu_nstall=0 at cycles 0,1,2; res_valid=1, alu_nstall=1 at cycle 3; IDLE at cycle 4; with ALU_MC_PERF_EN, perf_stall=3 and perf_mcops=1.
- fadd (0010000) with n_stall=0 held for 4 cycles after completion -> res_valid stays 1 for 5 cycles; exactly one unit_start; DONE->IDLE once n_stall=1.
- flt (0011001) followed immediately by fmul (0010010) -> stall 1 cycle, then valid, then IDLE, then stall 2 cycles, then valid; two unit_start pulses 3 cycles apart.
- fsqrt issue, then flush at cycle 1 -> IDLE at cycle 2; alu_nstall=1 at cycle 1; res_valid never asserted; perf_mcops unchanged.
- add (0000000), fneg (0010101) and feq (0011000) with issue_valid=1 -> op_lat=0, alu_nstall=1, no unit_start. Assert rst during RUN of fdiv -> next cycle IDLE, cnt=0.
